// File: rtl/noc_eject_port.sv
// Clocked responder on one NoC ejection port: completes the 4-phase rr/ra handshake,
// checks the per-flit activity toggle and queues {addr, uid, arrival stamp} for a consumer.
module noc_eject_port #(
    parameter int          ADDR_W      = 16,
    parameter int          UID_W       = 14,
    parameter int          ACT_W       = 2,
    parameter int          DEPTH       = 8,
    parameter int          SYNC_STAGES = 2,
    // Reset value of the stamp counter; nonzero only to reach the wrap point quickly.
    parameter logic [31:0] STAMP_INIT  = 32'h0,
    localparam int         FLIT_W      = ADDR_W + UID_W + ACT_W,
    localparam int         CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rr,
    input  logic [FLIT_W-1:0] dout,
    output logic              ra,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [UID_W-1:0]  out_uid,
    output logic [31:0]       out_stamp,
    output logic [CNT_W-1:0]  fifo_count,
    output logic [31:0]       flit_count,
    output logic              act_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // First expected activity value: the pattern ...1010, i.e. odd bits set.
    function automatic logic [ACT_W-1:0] act_seed();
        logic [ACT_W-1:0] v;
        for (int i = 0; i < ACT_W; i++) v[i] = ((i % 2) == 1);
        return v;
    endfunction

    localparam logic [ACT_W-1:0] ACT_SEED = act_seed();

    typedef enum logic {IDLE, ACK} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [UID_W-1:0]  uid;
        logic [31:0]       stamp;
    } entry_t;

    logic [SYNC_STAGES-1:0] rr_sync;
    logic                   rr_s;
    state_t                 state;
    logic [31:0]            stamp_cnt;
    logic [ACT_W-1:0]       exp_act;
    logic [ACT_W-1:0]       rx_act;

    entry_t                 mem [DEPTH];
    entry_t                 head;
    entry_t                 wr_entry;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign rr_s   = rr_sync[SYNC_STAGES-1];
    assign rx_act = dout[ACT_W-1:0];

    // dout has been stable for the whole synchronizer delay, so it is sampled raw.
    assign wr_entry = '{addr:  dout[FLIT_W-1 -: ADDR_W],
                        uid:   dout[ACT_W +: UID_W],
                        stamp: stamp_cnt};

    // Full is judged on occupancy before this cycle's pop, so a full FIFO never pushes.
    assign full      = (count == CNT_W'(DEPTH));
    assign push      = (state == IDLE) && rr_s && !full;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign head       = mem[rd_ptr];
    assign out_addr   = out_valid ? head.addr  : '0;
    assign out_uid    = out_valid ? head.uid   : '0;
    assign out_stamp  = out_valid ? head.stamp : '0;
    assign fifo_count = count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_sync    <= '0;
            state      <= IDLE;
            ra         <= 1'b0;
            stamp_cnt  <= STAMP_INIT;
            exp_act    <= ACT_SEED;
            act_err    <= 1'b0;
            flit_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rr_sync   <= {rr_sync[SYNC_STAGES-2:0], rr};
            stamp_cnt <= stamp_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (push) begin
                        state <= ACK;
                        ra    <= 1'b1;
                        if (flit_count != '1) flit_count <= flit_count + 32'd1;
                        if (rx_act != exp_act) act_err <= 1'b1;
                        // Resynchronise on the received value so one bad flit flags once.
                        exp_act <= ~rx_act;
                    end
                end
                ACK: begin
                    if (!rr_s) begin
                        state <= IDLE;
                        ra    <= 1'b0;
                    end
                end
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: tb/tb_noc_eject_port.sv
// Self-checking bench for noc_eject_port: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, randomized traffic and a stamp-wrap instance.
module tb_noc_eject_port;

    localparam int ADDR_W      = 16;
    localparam int UID_W       = 14;
    localparam int ACT_W       = 2;
    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FLIT_W      = ADDR_W + UID_W + ACT_W;
    localparam int CNT_W       = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rr;
    logic [FLIT_W-1:0] dout;
    logic              ra;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [UID_W-1:0]  out_uid;
    logic [31:0]       out_stamp;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       flit_count;
    logic              act_err;

    logic              w_rr;
    logic [FLIT_W-1:0] w_dout;
    logic              w_ra;
    logic              w_out_valid;
    logic              w_out_ready;
    logic [ADDR_W-1:0] w_out_addr;
    logic [UID_W-1:0]  w_out_uid;
    logic [31:0]       w_out_stamp;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [31:0]       w_flit_count;
    logic              w_act_err;

    always #5 clk = ~clk;

    noc_eject_port #(
        .ADDR_W(ADDR_W), .UID_W(UID_W), .ACT_W(ACT_W),
        .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rr(rr), .dout(dout), .ra(ra),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_uid(out_uid), .out_stamp(out_stamp), .fifo_count(fifo_count),
        .flit_count(flit_count), .act_err(act_err)
    );

    // Second instance whose stamp counter starts four counts before the 32-bit wrap.
    noc_eject_port #(
        .ADDR_W(ADDR_W), .UID_W(UID_W), .ACT_W(ACT_W),
        .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .STAMP_INIT(32'hFFFF_FFFC)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .rr(w_rr), .dout(w_dout), .ra(w_ra),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_addr(w_out_addr),
        .out_uid(w_out_uid), .out_stamp(w_out_stamp), .fifo_count(w_fifo_count),
        .flit_count(w_flit_count), .act_err(w_act_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [UID_W-1:0]  uid;
        logic [31:0]       stamp;
    } exp_t;

    exp_t        mq[$];       // expected FIFO contents, head at index 0
    bit          rr_hist[$];  // rr as seen by the DUT after the synchronizer delay
    bit          m_ra;
    bit          m_err;
    logic [1:0]  m_exp;
    logic [31:0] m_flits;
    logic [31:0] m_stamp;
    bit          m_live = 1'b0;
    bit          m_rr_s;
    bit          m_take;
    exp_t        m_e;
    int          max_fill;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            rr_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) rr_hist.push_back(1'b0);
            m_ra    = 1'b0;
            m_err   = 1'b0;
            m_exp   = 2'b10;
            m_flits = 32'd0;
            m_stamp = 32'd0;
            m_live  = 1'b1;
        end else begin
            m_rr_s = rr_hist[0];
            // A new flit is taken only when not mid-handshake and there is room before any pop.
            m_take = m_rr_s && !m_ra && (mq.size() < DEPTH);
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (m_take) begin
                m_e.addr  = dout[FLIT_W-1 -: ADDR_W];
                m_e.uid   = dout[ACT_W +: UID_W];
                m_e.stamp = m_stamp;
                mq.push_back(m_e);
                if (m_flits != 32'hFFFF_FFFF) m_flits = m_flits + 32'd1;
                if (dout[1:0] != m_exp) m_err = 1'b1;
                m_exp = ~dout[1:0];
            end
            m_ra = m_take || (m_ra && m_rr_s);
            void'(rr_hist.pop_front());
            rr_hist.push_back(rr);
            m_stamp = m_stamp + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ra", ra, m_ra);
            check("out_valid", out_valid, mq.size() > 0);
            check("fifo_count", fifo_count, mq.size());
            check("flit_count", flit_count, m_flits);
            check("act_err", act_err, m_err);
            if (mq.size() > 0) begin
                check("out_addr", out_addr, mq[0].addr);
                check("out_uid", out_uid, mq[0].uid);
                check("out_stamp", out_stamp, mq[0].stamp);
            end
            if (int'(fifo_count) > max_fill) max_fill = int'(fifo_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit         rand_phase = 1'b0;
    logic [1:0] cur_act;

    always @(negedge clk) begin
        if (rand_phase) out_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic wait_ra(input logic v, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ra !== v && n < 200);
        check(name, ra, v);
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [UID_W-1:0] u,
                        input logic [ACT_W-1:0] act);
        int n;
        dout = {a, u, act};
        rr   = 1'b1;
        wait_ra(1'b1, "ra_rise", n);
        rr = 1'b0;
        wait_ra(1'b0, "ra_fall", n);
    endtask

    // Sends with the correct toggling activity value.
    task automatic send_ok(input logic [ADDR_W-1:0] a, input logic [UID_W-1:0] u);
        send(a, u, cur_act);
        cur_act = ~cur_act;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int         n;
        logic [1:0] act;

        rst_n       = 1'b0;
        rr          = 1'b0;
        dout        = '0;
        out_ready   = 1'b0;
        w_rr        = 1'b0;
        w_dout      = '0;
        w_out_ready = 1'b0;
        max_fill    = 0;

        repeat (2) @(negedge clk);
        check("rst_ra", ra, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_flit_count", flit_count, 0);
        check("rst_act_err", act_err, 1'b0);
        check("rst_out_addr", out_addr, 0);

        // Single flit, released together with reset: capture on the third edge at stamp 2.
        rst_n = 1'b1;
        dout  = {16'h00A5, 14'h0123, 2'b10};
        rr    = 1'b1;
        wait_ra(1'b1, "single_ra_rise", n);
        check("single_rise_latency", n, SYNC_STAGES + 1);
        check("single_addr", out_addr, 16'h00A5);
        check("single_uid", out_uid, 14'h0123);
        check("single_stamp", out_stamp, 32'd2);
        rr = 1'b0;
        wait_ra(1'b0, "single_ra_fall", n);
        check("single_fall_latency", n, SYNC_STAGES + 1);
        check("single_flit_count", flit_count, 1);
        check("single_act_err", act_err, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("single_popped", fifo_count, 0);

        // 20 back-to-back flits drained as they arrive.
        do_reset();
        cur_act   = 2'b10;
        out_ready = 1'b1;
        max_fill  = 0;
        for (int i = 0; i < 20; i++) send_ok(ADDR_W'(16'h1000 + i), UID_W'(i * 3 + 1));
        @(negedge clk);
        check("b2b_flit_count", flit_count, 20);
        check("b2b_act_err", act_err, 1'b0);
        check("b2b_drained", fifo_count, 0);
        check("b2b_max_fill_le1", max_fill <= 1, 1'b1);

        // Backpressure: fill to DEPTH, ninth flit must wait until one pop frees a slot.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_ok(ADDR_W'(16'h2000 + i), UID_W'(i));
        dout = {16'h2008, 14'h0008, cur_act};
        rr   = 1'b1;
        repeat (10) @(negedge clk);
        check("full_ra_held_low", ra, 1'b0);
        check("full_count", fifo_count, DEPTH);
        check("full_head_addr", out_addr, 16'h2000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("full_after_pop", fifo_count, DEPTH - 1);
        @(negedge clk);
        check("ninth_acked", ra, 1'b1);
        check("ninth_refill", fifo_count, DEPTH);
        rr = 1'b0;
        wait_ra(1'b0, "ninth_ra_fall", n);
        cur_act = ~cur_act;
        check("bp_flit_count", flit_count, 29);
        out_ready = 1'b1;
        repeat (DEPTH + 1) @(negedge clk);
        out_ready = 1'b0;
        check("bp_drained", fifo_count, 0);

        // Activity repeat: second 10 flags the error, a following 01 is in step but the flag sticks.
        do_reset();
        send(16'h3000, 14'h0001, 2'b10);
        check("act_first_ok", act_err, 1'b0);
        send(16'h3001, 14'h0002, 2'b10);
        check("act_repeat_err", act_err, 1'b1);
        send(16'h3002, 14'h0003, 2'b01);
        check("act_err_sticky", act_err, 1'b1);
        check("act_all_stored", fifo_count, 3);

        // Reset while acknowledging with three entries queued; rr stays high and is recaptured.
        do_reset();
        cur_act = 2'b10;
        send_ok(16'h4000, 14'h0010);
        send_ok(16'h4001, 14'h0011);
        dout = {16'h4002, 14'h0012, cur_act};
        rr   = 1'b1;
        wait_ra(1'b1, "mid_ra_rise", n);
        check("mid_queued", fifo_count, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ra", ra, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_flits", flit_count, 0);
        check("mid_rst_addr", out_addr, 0);
        rst_n = 1'b1;
        wait_ra(1'b1, "recapture_ra", n);
        check("recapture_latency", n, SYNC_STAGES + 1);
        check("recapture_count", fifo_count, 1);
        check("recapture_flits", flit_count, 1);
        check("recapture_addr", out_addr, 16'h4002);
        rr = 1'b0;
        wait_ra(1'b0, "recapture_ra_fall", n);

        // Randomized traffic with occasional wrong activity values and random consumer stalls.
        do_reset();
        cur_act    = 2'b10;
        rand_phase = 1'b1;
        for (int i = 0; i < 300; i++) begin
            act = ($urandom_range(0, 9) == 0) ? 2'($urandom) : cur_act;
            send(ADDR_W'($urandom), UID_W'($urandom), act);
            cur_act = ~act;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_phase = 1'b0;
        out_ready  = 1'b1;
        repeat (DEPTH + 1) @(negedge clk);
        out_ready = 1'b0;
        check("rand_drained", fifo_count, 0);

        // Stamp wrap: captures on edges 3 and 9 after release -> 0xFFFFFFFE and 0x00000004.
        do_reset();
        w_dout = {16'hBEEF, 14'h0001, 2'b10};
        w_rr   = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("wrap_ra_rise1", w_ra, 1'b1);
        check("wrap_stamp1", w_out_stamp, 32'hFFFF_FFFE);
        w_rr = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("wrap_ra_fall1", w_ra, 1'b0);
        w_dout = {16'hCAFE, 14'h0002, 2'b01};
        w_rr   = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        check("wrap_ra_rise2", w_ra, 1'b1);
        check("wrap_count", w_fifo_count, 2);
        w_rr        = 1'b0;
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        check("wrap_addr2", w_out_addr, 16'hCAFE);
        check("wrap_stamp2", w_out_stamp, 32'h0000_0004);
        check("wrap_act_err", w_act_err, 1'b0);
        check("wrap_flit_count", w_flit_count, 2);

        repeat (SYNC_STAGES + 2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
